// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEPTH_DEF    = 64;
  localparam int unsigned LOCK_MAX_DEF = 16;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StHlock = 1'b1;

  // Round-robin pointer: which requester wins a tie.
  localparam logic PtrCore = 1'b0;
  localparam logic PtrHost = 1'b1;

  // Owner of the read data returning in the next cycle.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCore = 2'd1,
    OwnHost = 2'd2
  } rv_owner_e;

  function automatic int unsigned lock_cnt_w(input int unsigned lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/dmem_addr_chk.sv
// Flags a byte address that is misaligned or beyond the last memory word.
module dmem_addr_chk #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              err_o
);

  localparam logic [ADDR_W:0] Limit = (ADDR_W + 1)'(4 * DEPTH);

  assign err_o = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= Limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory: round-robin grants, host lock,
// address checking and read-return routing. DMEM_ARB_PERF_EN adds a core stall counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_c_req,
  input  logic              i_c_wen,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_ack,
  output logic              o_c_err,
  output logic              o_c_rvalid,
  input  logic              i_h_req,
  input  logic              i_h_wen,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  input  logic              i_h_lock,
  output logic              o_h_ack,
  output logic              o_h_err,
  output logic              o_h_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_d_wen,
  output logic [ADDR_W-1:0] o_d_addr,
  output logic [DATA_W-1:0] o_d_wdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]       o_c_stall_cnt,
`endif
  input  logic [DATA_W-1:0] i_d_rdata
);

  localparam int unsigned CntW = lock_cnt_w(LOCK_MAX);

  logic            c_err, h_err;
  logic            c_gnt, h_gnt;
  logic [0:0]      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rv_owner_e       owner_q, owner_d;

  dmem_addr_chk #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_chk_core (
    .addr_i (i_c_addr),
    .err_o  (c_err)
  );

  dmem_addr_chk #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_chk_host (
    .addr_i (i_h_addr),
    .err_o  (h_err)
  );

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (!i_rst) begin
      if (state_q == StHlock) begin
        h_gnt = i_h_req;
      end else if (i_c_req && i_h_req) begin
        c_gnt = (ptr_q == PtrCore);
        h_gnt = (ptr_q == PtrHost);
      end else begin
        c_gnt = i_c_req;
        h_gnt = i_h_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (c_gnt) ptr_d = PtrHost;
    if (h_gnt) ptr_d = PtrCore;

    if (state_q == StIdle) begin
      if (h_gnt && !h_err && i_h_lock) begin
        state_d = StHlock;
        cnt_d   = CntW'(1);
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(LOCK_MAX)) begin
        // Forced release: the host's access this cycle still goes ahead.
        state_d = StIdle;
        cnt_d   = '0;
        ptr_d   = PtrCore;
      end else if (!i_h_lock && (h_gnt || !i_h_req)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    owner_d = OwnNone;
    if (c_gnt && !c_err && !i_c_wen) owner_d = OwnCore;
    if (h_gnt && !h_err && !i_h_wen) owner_d = OwnHost;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      ptr_q   <= PtrCore;
      cnt_q   <= '0;
      owner_q <= OwnNone;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    o_d_wen   = 1'b0;
    o_d_addr  = '0;
    o_d_wdata = '0;
    if (c_gnt) begin
      o_d_wen   = i_c_wen & ~c_err;
      o_d_addr  = i_c_addr;
      o_d_wdata = i_c_wdata;
    end else if (h_gnt) begin
      o_d_wen   = i_h_wen & ~h_err;
      o_d_addr  = i_h_addr;
      o_d_wdata = i_h_wdata;
    end
  end

  assign o_c_ack    = c_gnt;
  assign o_c_err    = c_gnt & c_err;
  assign o_h_ack    = h_gnt;
  assign o_h_err    = h_gnt & h_err;
  assign o_c_rvalid = (owner_q == OwnCore);
  assign o_h_rvalid = (owner_q == OwnHost);
  assign o_rdata    = (owner_q != OwnNone) ? i_d_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (i_c_req && !c_gnt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_c_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_wen = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        h_req = 1'b0, h_wen = 1'b0, h_lock = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic        c_ack, c_err, c_rvalid, h_ack, h_err, h_rvalid, d_wen;
  logic [31:0] rdata, d_addr, d_wdata;
  logic [31:0] d_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_c_req    (c_req),
    .i_c_wen    (c_wen),
    .i_c_addr   (c_addr),
    .i_c_wdata  (c_wdata),
    .o_c_ack    (c_ack),
    .o_c_err    (c_err),
    .o_c_rvalid (c_rvalid),
    .i_h_req    (h_req),
    .i_h_wen    (h_wen),
    .i_h_addr   (h_addr),
    .i_h_wdata  (h_wdata),
    .i_h_lock   (h_lock),
    .o_h_ack    (h_ack),
    .o_h_err    (h_err),
    .o_h_rvalid (h_rvalid),
    .o_rdata    (rdata),
    .o_d_wen    (d_wen),
    .o_d_addr   (d_addr),
    .o_d_wdata  (d_wdata),
`ifdef DMEM_ARB_PERF_EN
    .o_c_stall_cnt (stall_cnt),
`endif
    .i_d_rdata  (d_rdata)
  );

  // The physical memory behind the arbiter (environment, not the reference).
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  always @(posedge clk) begin
    d_rdata <= mem[d_addr[7:2]];
    if (d_wen) mem[d_addr[7:2]] <= d_wdata;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  // Reference model: who owns the memory, what it holds, what comes back next cycle.
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
  bit          locked = 0;
  int          lock_cycles = 0;
  int          favour = 0;       // 0: core wins a tie, 1: host wins a tie
  int          rd_from = 0;      // 0 none, 1 core, 2 host
  logic [31:0] rd_val = '0;
  bit          exp_c_ack = 0, exp_h_ack = 0;
  int unsigned stalls = 0;

  always @(negedge clk) begin : model
    bit gc, gh, ce, he, wr_ok;
    if (rst) begin
      chk32("rst_outs", {25'd0, c_ack, c_err, c_rvalid, h_ack, h_err, h_rvalid, d_wen}, 32'd0);
      chk32("rst_rdata", rdata, 32'd0);
      chk32("rst_d_addr", d_addr, 32'd0);
      chk32("rst_d_wdata", d_wdata, 32'd0);
      locked = 0; lock_cycles = 0; favour = 0; rd_from = 0;
      exp_c_ack = 0; exp_h_ack = 0; stalls = 0;
`ifdef DMEM_ARB_PERF_EN
      chk32("rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    end else begin
      gc = 0; gh = 0;
      if (locked) gh = h_req;
      else if (c_req && h_req) begin gc = (favour == 0); gh = !gc; end
      else begin gc = c_req; gh = h_req; end
      ce = bad(c_addr);
      he = bad(h_addr);

      chk1("c_ack", c_ack, gc);
      chk1("c_err", c_err, gc && ce);
      chk1("h_ack", h_ack, gh);
      chk1("h_err", h_err, gh && he);
      wr_ok = (gc && c_wen && !ce) || (gh && h_wen && !he);
      chk1("d_wen", d_wen, wr_ok);
      if (!gc && !gh) begin
        chk32("idle_d_addr", d_addr, 32'd0);
        chk32("idle_d_wdata", d_wdata, 32'd0);
      end else if (gc && !ce) begin
        chk32("c_d_addr", d_addr, c_addr);
        if (c_wen) chk32("c_d_wdata", d_wdata, c_wdata);
      end else if (gh && !he) begin
        chk32("h_d_addr", d_addr, h_addr);
        if (h_wen) chk32("h_d_wdata", d_wdata, h_wdata);
      end
      chk1("c_rvalid", c_rvalid, rd_from == 1);
      chk1("h_rvalid", h_rvalid, rd_from == 2);
      chk32("rdata", rdata, (rd_from != 0) ? rd_val : 32'd0);
`ifdef DMEM_ARB_PERF_EN
      chk32("stall_cnt", {16'd0, stall_cnt}, stalls);
      if (c_req && !gc && stalls < 32'hFFFF) stalls++;
`endif

      rd_from = 0;
      if (gc && !ce && !c_wen) begin rd_from = 1; rd_val = ref_mem[c_addr[7:2]]; end
      if (gh && !he && !h_wen) begin rd_from = 2; rd_val = ref_mem[h_addr[7:2]]; end
      if (gc && !ce && c_wen) ref_mem[c_addr[7:2]] = c_wdata;
      if (gh && !he && h_wen) ref_mem[h_addr[7:2]] = h_wdata;
      if (gc) favour = 1;
      if (gh) favour = 0;
      if (locked) begin
        if (lock_cycles == LOCK_MAX) begin locked = 0; favour = 0; end
        else if (!h_lock && (gh || !h_req)) locked = 0;
        else lock_cycles++;
      end else if (gh && !he && h_lock) begin
        locked = 1; lock_cycles = 1;
      end
      exp_c_ack = gc;
      exp_h_ack = gh;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c_req = 0; c_wen = 0; c_addr = '0; c_wdata = '0;
    h_req = 0; h_wen = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1;
    idle_inputs();
    nxt();
    rst = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return $urandom_range(0, 511);
    return $urandom_range(0, DEPTH - 1) * 32'd4;
  endfunction

  task automatic new_core();
    c_req   = ($urandom_range(0, 3) != 0);
    c_wen   = ($urandom_range(0, 1) == 1);
    c_addr  = pick_addr();
    c_wdata = $urandom;
  endtask

  task automatic new_host();
    h_req   = ($urandom_range(0, 2) == 0);
    h_wen   = ($urandom_range(0, 1) == 1);
    h_addr  = pick_addr();
    h_wdata = $urandom;
    h_lock  = h_req && ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    idle_inputs();
    smp();
    chk1("t0_c_ack", c_ack, 1'b0);
    chk1("t0_c_rvalid", c_rvalid, 1'b0);
    chk32("t0_rdata", rdata, 32'd0);
    nxt();
    rst = 0;

    // Core read after host preload of word 4.
    h_req = 1; h_wen = 1; h_addr = 32'h10; h_wdata = 32'hDEADBEEF;
    smp(); chk1("t1_h_ack", h_ack, 1'b1);
    nxt(); h_req = 0; c_req = 1; c_wen = 0; c_addr = 32'h10;
    smp(); chk1("t1_c_ack", c_ack, 1'b1); chk1("t1_rv_early", c_rvalid, 1'b0);
    nxt(); c_req = 0;
    smp(); chk1("t1_c_rvalid", c_rvalid, 1'b1); chk32("t1_rdata", rdata, 32'hDEADBEEF);

    // Both requesting every cycle from reset: strict alternation starting with core.
    do_reset();
    c_req = 1; c_wen = 1; c_addr = 32'h0; c_wdata = 32'hA0A0_0001;
    h_req = 1; h_wen = 1; h_addr = 32'h4; h_wdata = 32'hB0B0_0002;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk1("t2_c_ack", c_ack, (k % 2) == 0);
      chk1("t2_h_ack", h_ack, (k % 2) == 1);
      nxt();
    end
    idle_inputs();

    // Out-of-range and misaligned core writes are rejected without touching memory.
    c_req = 1; c_wen = 1; c_addr = 32'h102; c_wdata = 32'h0000_0BAD;
    smp(); chk1("t5_ack_a", c_ack, 1'b1); chk1("t5_err_a", c_err, 1'b1); chk1("t5_wen_a", d_wen, 1'b0);
    nxt(); c_addr = 32'h100;
    smp(); chk1("t5_ack_b", c_ack, 1'b1); chk1("t5_err_b", c_err, 1'b1); chk1("t5_wen_b", d_wen, 1'b0);
    chk1("t5_rv_a", c_rvalid, 1'b0);
    nxt(); c_wen = 0; c_addr = 32'h0;
    smp(); chk1("t5_err_c", c_err, 1'b0); chk1("t5_rv_b", c_rvalid, 1'b0);
    nxt(); c_req = 0;
    smp(); chk1("t5_rv_c", c_rvalid, 1'b1); chk32("t5_mem0", rdata, 32'hA0A0_0001);

    // Host lock for three accesses, released by a lock=0 write.
    do_reset();
    h_req = 1; h_wen = 0; h_addr = 32'h8; h_lock = 1;
    smp(); chk1("t3_h_ack0", h_ack, 1'b1);
    nxt(); c_req = 1; c_wen = 0; c_addr = 32'h20;
    for (int k = 0; k < 2; k++) begin
      smp(); chk1("t3_c_blk", c_ack, 1'b0); chk1("t3_h_ack", h_ack, 1'b1);
      nxt();
    end
    h_wen = 1; h_lock = 0; h_wdata = 32'h5;
    smp(); chk1("t3_c_blk_last", c_ack, 1'b0); chk1("t3_h_unlock", h_ack, 1'b1);
    nxt(); h_req = 0;
    smp(); chk1("t3_c_ack", c_ack, 1'b1);
    nxt(); idle_inputs();

    // Lock held continuously: forced release after LOCK_MAX locked cycles.
    do_reset();
    h_req = 1; h_wen = 0; h_addr = 32'hC; h_lock = 1;
    smp(); chk1("t4_h_entry", h_ack, 1'b1);
    nxt(); c_req = 1; c_wen = 0; c_addr = 32'h24;
    for (int k = 1; k <= int'(LOCK_MAX); k++) begin
      smp(); chk1("t4_c_blk", c_ack, 1'b0); chk1("t4_h_ack", h_ack, 1'b1);
      nxt();
    end
    smp(); chk1("t4_c_release", c_ack, 1'b1); chk1("t4_h_wait", h_ack, 1'b0);
    nxt(); idle_inputs();

    // Reset in the cycle after a core read ack kills the pending rvalid.
    c_req = 1; c_wen = 0; c_addr = 32'h10;
    smp(); chk1("t6_c_ack", c_ack, 1'b1);
    nxt(); c_req = 0; rst = 1;
    smp(); chk1("t6_rv_rst", c_rvalid, 1'b0); chk32("t6_rdata_rst", rdata, 32'd0);
    nxt(); rst = 0;
    smp(); chk1("t6_rv_after", c_rvalid, 1'b0);

    // Random traffic after filling memory with known contents.
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      h_req = 1; h_wen = 1; h_lock = 0; h_addr = 32'(i) * 32'd4; h_wdata = $urandom;
      nxt();
    end
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if (!c_req || exp_c_ack) new_core();
      if (!h_req || exp_h_ack) new_host();
    end
    nxt();
    idle_inputs();
    nxt();
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: the core load/store port and a host/debug port (preload and readback).
- Sits between `core`/host and `data_mem`.
- Provides round-robin arbitration, host lock for atomic read-modify-write sequences, address checking and read-data return routing.
- The core sees a stall whenever it has a request outstanding without `o_c_ack`.

Parameters:
- ADDR_W, 32, byte-address width of both request ports and the memory port
- DATA_W, 32, data word width
- DEPTH, 64, number of memory words; legal byte addresses are 0 to 4*DEPTH-4
- LOCK_MAX, 16, maximum consecutive host-locked cycles before forced release

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_c_req  in  1  core access request
- i_c_wen  in  1  core write enable (0 = read)
- i_c_addr  in  ADDR_W  core byte address
- i_c_wdata  in  DATA_W  core write data
- o_c_ack  out  1  core access accepted this cycle
- o_c_err  out  1  core access rejected (qualifies o_c_ack)
- o_c_rvalid  out  1  read data for core valid on o_rdata
- i_h_req  in  1  host access request
- i_h_wen  in  1  host write enable
- i_h_addr  in  ADDR_W  host byte address
- i_h_wdata  in  DATA_W  host write data
- i_h_lock  in  1  host requests exclusive ownership after this access
- o_h_ack  out  1  host access accepted this cycle
- o_h_err  out  1  host access rejected
- o_h_rvalid  out  1  read data for host valid on o_rdata
- o_rdata  out  DATA_W  shared read-return data
- o_d_wen  out  1  memory write enable
- o_d_addr  out  ADDR_W  memory byte address
- o_d_wdata  out  DATA_W  memory write data
- i_d_rdata  in  DATA_W  memory read data, valid one cycle after the address

Behaviour:
- **Reset (async, while i_rst=1):**
  - all outputs 0; state IDLE; round-robin pointer favours core; lock counter 0; rvalid pipeline cleared.
  - Reset mid-lock or mid-read drops everything; no rvalid is issued afterwards.
- **Request/ack:**
  - Requester holds req/wen/addr/wdata stable until ack.
  - Grant is combinational: the winner's ack is high in the same cycle N, with o_d_* driven from the winner.
  - Reads: the matching rvalid is registered high in N+1, and o_rdata = i_d_rdata in N+1.
  - Writes: no rvalid.
  - o_rdata = 0 when neither rvalid is high.
  - Back-to-back grants every cycle are allowed (one in flight).
- **No grant:** o_d_wen=0, o_d_addr=0, o_d_wdata=0.
- **Arbitration in IDLE:**
  - Single requester: granted immediately.
  - Both requesting: pointer owner wins; after every grant the pointer moves to the other requester (last-granted is lowest priority).
- **Address check, per port:**
  - err if addr[1:0]!=0 or addr >= 4*DEPTH.
  - An error grant raises ack+err, forces o_d_wen=0, gives no rvalid, and still consumes the slot and moves the pointer.
- **States:** IDLE, HLOCK.
  - IDLE->HLOCK on a non-error host grant with i_h_lock=1; lock counter loads 1.
  - In HLOCK:
    - only the host is granted; o_c_ack=0 even if the core requests; counter increments each cycle.
    - HLOCK->IDLE when the host is granted with i_h_lock=0 (that access completes), or when i_h_lock=0 with i_h_req=0, or when the counter reaches LOCK_MAX.
    - On the LOCK_MAX exit: the grant in that cycle still proceeds, and the pointer is forced to core.
- **Simultaneous events:** a core read's rvalid in N+1 coexists with a host grant in N+1. The rvalids are one-hot by construction.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds port `o_c_stall_cnt` (out, 16): a saturating count of cycles with i_c_req=1 and o_c_ack=0. It clears only on reset and holds at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, HLOCK}
  - DEPTH default
  - LOCK counter width localparam, computed from LOCK_MAX
  - rvalid owner encoding
- One sub-module, dmem_addr_chk (combinational alignment/range check), instantiated twice, once per port.

Test Plan:
- Core-only read of 0x10 with mem[4]=0xDEADBEEF: o_c_ack in N, o_c_rvalid and o_rdata=0xDEADBEEF in N+1.
- Both ports request every cycle (writes 0x0 and 0x4) from reset: acks alternate core, host, core, host; no cycle has both acks.
- Host lock at 0x8 with i_h_lock=1 for 3 cycles while core requests: core ack blocked exactly while locked; core granted the cycle after the host's lock=0 access.
- Host holds lock with continuous requests and LOCK_MAX=16: forced release after 16 cycles, then core acked next cycle.
- Core addresses 0x102 and 0x100: both get ack+err, o_d_wen=0, no rvalid; memory unchanged.
- Assert i_rst in the cycle after a core read ack: o_c_rvalid stays 0 and all outputs are 0 within the reset.
